// File: rtl/obuf_ctrl.sv
// obuf_ctrl -- output-buffer controller for one router output port.
//
// The flit picked by this output's arbiter is written into a small FIFO,
// and the FIFO head is sent downstream over a valid/ready link.
// obuf_rdy, link_vld and link_payload are decoded from registers only, so
// there is no combinational path from arb_gnt or link_rdy to any output.
// A flit pushed in cycle t is presented downstream in cycle t+1.
//
// Parameters
//   PYLD_W        payload width in bits (default `PKT_W)
//   DEPTH         FIFO entries, a power of two >= 2
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset (count and pointers only)
//   arb_gnt[4:0]  one-hot grant, bit d selects payload_in slice d
//                 (bit positions per `DIR_N/`DIR_S/`DIR_E/`DIR_W/`DIR_B)
//   payload_in    five payloads, slice [d*PYLD_W +: PYLD_W] for direction d
//   obuf_rdy      one flit can be accepted this cycle
//   link_vld      downstream valid
//   link_rdy      downstream ready
//   link_payload  downstream flit, driven from the FIFO head
//   stall_cnt     (only with OBUF_STALL_CNT_EN) saturating count of cycles
//                 with link_vld=1 and link_rdy=0
//
// Build option: define OBUF_STALL_CNT_EN to add the stall_cnt port.

`ifndef PKT_W
`define PKT_W 8
`endif
`ifndef DIR_N
`define DIR_N 0
`endif
`ifndef DIR_S
`define DIR_S 1
`endif
`ifndef DIR_E
`define DIR_E 2
`endif
`ifndef DIR_W
`define DIR_W 3
`endif
`ifndef DIR_B
`define DIR_B 4
`endif

module obuf_ctrl #(
    parameter int PYLD_W = `PKT_W,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            arb_gnt,
    input  logic [5*PYLD_W-1:0]   payload_in,
    output logic                  obuf_rdy,
    output logic                  link_vld,
    input  logic                  link_rdy,
    output logic [PYLD_W-1:0]     link_payload
`ifdef OBUF_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [PYLD_W-1:0]  mem_q [DEPTH];

    logic [4:0]         gnt_low;
    logic [PYLD_W-1:0]  masked [5];
    logic [PYLD_W-1:0]  sel_payload;
    logic               push;
    logic               pop;

    // Isolate the lowest set grant bit so a malformed multi-hot grant still
    // selects exactly one slice, deterministically.
    assign gnt_low = arb_gnt & (~arb_gnt + 5'd1);

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_mask
            assign masked[gi] = payload_in[gi*PYLD_W +: PYLD_W] & {PYLD_W{gnt_low[gi]}};
        end
    endgenerate

    always_comb begin
        sel_payload = '0;
        for (int d = 0; d < 5; d++) begin
            sel_payload = sel_payload | masked[d];
        end
    end

    // All three outputs come straight from state; a pop while full does not
    // open obuf_rdy until the following cycle.
    assign obuf_rdy     = (count_q < DEPTH_C);
    assign link_vld     = (count_q != '0);
    assign link_payload = mem_q[rd_ptr_q];

    assign push = (|arb_gnt) & obuf_rdy;
    assign pop  = link_vld & link_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; its contents are only observed
    // while link_vld is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sel_payload;
        end
    end

`ifdef OBUF_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (link_vld && !link_rdy && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
